// File: rtl/uart_rx_if.sv
// Serial receive bundle: the raw line in, the received word and status strobes out.
// master is the receiver side, slave is the line driver / word consumer.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 rx_busy;

    modport master (
        input  rx,
        output rx_data, rx_valid, frame_err, parity_err, rx_busy
    );

    modport slave (
        output rx,
        input  rx_data, rx_valid, frame_err, parity_err, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_BITS LSB-first, optional even parity, one stop bit.
// Define UART_RX_PARITY_EN to expect the parity bit before the stop bit.
module uart_rx #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50000000,
    parameter int DATA_BITS  = 8
) (
    input  logic     clock,
    input  logic     reset,
    uart_rx_if.master bus
);
    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int BIT_PERIOD = BIT_CYCLES + 1;
    localparam int HALF       = BIT_PERIOD / 2;
    localparam int CW         = $clog2(BIT_PERIOD + 1);
    localparam int BW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state, state_d;
    logic [CW-1:0]        clk_cnt, clk_d;
    logic [BW-1:0]        bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_m, rx_s;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    assign tick = (clk_cnt == CW'(BIT_PERIOD - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_m    <= bus.rx;
            rx_s    <= rx_m;
            state   <= state_d;
            clk_cnt <= clk_d;
            bit_cnt <= bit_d;
            shift   <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        clk_d   = clk_cnt;
        bit_d   = bit_cnt;
        shift_d = shift;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                clk_d = '0;
                bit_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                clk_d = clk_cnt + 1'b1;
                if (clk_cnt == CW'(HALF - 1)) begin
                    clk_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                clk_d = clk_cnt + 1'b1;
                if (tick) begin
                    clk_d   = '0;
                    shift_d = DATA_BITS'({rx_s, shift} >> 1);
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                clk_d = clk_cnt + 1'b1;
                if (tick) begin
                    clk_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                clk_d = clk_cnt + 1'b1;
                if (tick) begin
                    clk_d = '0;
                    if (rx_s) begin
                        data_d  = shift;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{shift, par_q};
`endif
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // stay here through a break so only one error is reported
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level line driver, strobe monitor and expected-word model.
module tb_uart_rx;
    localparam int CF = 16;
    localparam int BR = 1;
    localparam int DB = 8;
    localparam int BP = CF / BR + 1;
`ifdef UART_RX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .BAUD_RATE(BR),
        .CLOCK_FREQ(CF),
        .DATA_BITS(DB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int errs = 0;
    int nchk = 0;

    logic [7:0] vq[$];
    int         vt[$];
    bit         vp[$];
    int         cyc = 0;
    int         ferr_n = 0;
    int         both_n = 0;
    int         plone_n = 0;
    logic [7:0] last_good = 8'h00;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (bus.rx_valid) begin
                vq.push_back(bus.rx_data);
                vt.push_back(cyc);
                vp.push_back(bus.parity_err);
                if (bus.frame_err) both_n <= both_n + 1;
            end else if (bus.parity_err) begin
                plone_n <= plone_n + 1;
            end
            if (bus.frame_err) ferr_n <= ferr_n + 1;
        end
    end

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (BP) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ bad_par);
`endif
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        nchk++;
        if (bus.rx_data !== 8'h00) begin
            errs++; $display("FAIL reset_data got=%h exp=00", bus.rx_data);
        end
        nchk++;
        if (bus.rx_valid !== 1'b0) begin
            errs++; $display("FAIL reset_valid got=%b exp=0", bus.rx_valid);
        end
        nchk++;
        if (bus.frame_err !== 1'b0) begin
            errs++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err);
        end
        nchk++;
        if (bus.parity_err !== 1'b0) begin
            errs++; $display("FAIL reset_perr got=%b exp=0", bus.parity_err);
        end
        nchk++;
        if (bus.rx_busy !== 1'b0) begin
            errs++; $display("FAIL reset_busy got=%b exp=0", bus.rx_busy);
        end
        reset = 1'b0;
        idle(5);
    endtask

    task automatic test_single();
        int n0 = vq.size();
        int f0 = ferr_n;
        send_frame(8'h55, 1'b1, 1'b0);
        idle(3);
        nchk++;
        if (vq.size() - n0 !== 1) begin
            errs++; $display("FAIL single_count got=%0d exp=1", vq.size() - n0);
        end else begin
            nchk++;
            if (vq[n0] !== 8'h55) begin
                errs++; $display("FAIL single_data got=%h exp=55", vq[n0]);
            end
        end
        nchk++;
        if (ferr_n - f0 !== 0) begin
            errs++; $display("FAIL single_ferr got=%0d exp=0", ferr_n - f0);
        end
        nchk++;
        if (bus.rx_data !== 8'h55) begin
            errs++; $display("FAIL single_hold got=%h exp=55", bus.rx_data);
        end
        last_good = 8'h55;
    endtask

    task automatic test_back_to_back();
        int n0 = vq.size();
        send_frame(8'hAB, 1'b1, 1'b0);
        send_frame(8'h2A, 1'b1, 1'b0);
        idle(3);
        nchk++;
        if (vq.size() - n0 !== 2) begin
            errs++; $display("FAIL b2b_count got=%0d exp=2", vq.size() - n0);
        end else begin
            nchk++;
            if (vq[n0] !== 8'hAB || vq[n0+1] !== 8'h2A) begin
                errs++;
                $display("FAIL b2b_data got=%h,%h exp=ab,2a", vq[n0], vq[n0+1]);
            end
            nchk++;
            if (vt[n0+1] - vt[n0] !== FB * BP) begin
                errs++;
                $display("FAIL b2b_gap got=%0d exp=%0d", vt[n0+1] - vt[n0], FB * BP);
            end
        end
        last_good = 8'h2A;
    endtask

    task automatic test_glitch();
        int n0 = vq.size();
        int f0 = ferr_n;
        bus.rx = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        nchk++;
        if (bus.rx_busy !== 1'b1) begin
            errs++; $display("FAIL glitch_busy_hi got=%b exp=1", bus.rx_busy);
        end
        @(posedge clock);
        #1;
        idle(20);
        nchk++;
        if (bus.rx_busy !== 1'b0) begin
            errs++; $display("FAIL glitch_busy_lo got=%b exp=0", bus.rx_busy);
        end
        nchk++;
        if (vq.size() != n0 || ferr_n != f0) begin
            errs++;
            $display("FAIL glitch_strobe got=%0d/%0d exp=0/0", vq.size() - n0, ferr_n - f0);
        end
    endtask

    task automatic test_frame_err();
        int n0 = vq.size();
        int f0 = ferr_n;
        send_frame(8'hAA, 1'b0, 1'b0);
        repeat (100) @(posedge clock);
        #1;
        nchk++;
        if (ferr_n - f0 !== 1) begin
            errs++; $display("FAIL ferr_count got=%0d exp=1", ferr_n - f0);
        end
        nchk++;
        if (vq.size() - n0 !== 0) begin
            errs++; $display("FAIL ferr_valid got=%0d exp=0", vq.size() - n0);
        end
        nchk++;
        if (bus.rx_data !== last_good) begin
            errs++; $display("FAIL ferr_hold got=%h exp=%h", bus.rx_data, last_good);
        end
        nchk++;
        if (bus.rx_busy !== 1'b1) begin
            errs++; $display("FAIL ferr_busy_hi got=%b exp=1", bus.rx_busy);
        end
        idle(5);
        nchk++;
        if (bus.rx_busy !== 1'b0) begin
            errs++; $display("FAIL ferr_busy_lo got=%b exp=0", bus.rx_busy);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp[$];
        int n0 = vq.size();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] d = 8'($urandom);
            idle($urandom_range(0, 30));
            send_frame(d, 1'b1, 1'b0);
            exp.push_back(d);
        end
        idle(3);
        nchk++;
        if (vq.size() - n0 !== exp.size()) begin
            errs++;
            $display("FAIL rand_count got=%0d exp=%0d", vq.size() - n0, exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                nchk++;
                if (vq[n0+k] !== exp[k] || vp[n0+k] !== 1'b0) begin
                    errs++;
                    $display("FAIL rand_data[%0d] got=%h/p%b exp=%h/p0",
                             k, vq[n0+k], vp[n0+k], exp[k]);
                end
            end
            last_good = exp[exp.size()-1];
        end
    endtask

    task automatic test_reset_mid();
        int n0 = vq.size();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #2;
        reset = 1'b1;
        #1;
        nchk++;
        if (bus.rx_busy !== 1'b0 || bus.rx_data !== 8'h00) begin
            errs++;
            $display("FAIL rmid_out got=%b/%h exp=0/00", bus.rx_busy, bus.rx_data);
        end
        bus.rx = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(5);
        nchk++;
        if (vq.size() - n0 !== 0) begin
            errs++; $display("FAIL rmid_strobe got=%0d exp=0", vq.size() - n0);
        end
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(3);
        nchk++;
        if (vq.size() - n0 !== 1 || bus.rx_data !== 8'h0F) begin
            errs++;
            $display("FAIL rmid_next got=%0d/%h exp=1/0f", vq.size() - n0, bus.rx_data);
        end
        last_good = 8'h0F;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int n0 = vq.size();
        send_frame(8'h03, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1);
        idle(3);
        nchk++;
        if (vq.size() - n0 !== 2) begin
            errs++; $display("FAIL par_count got=%0d exp=2", vq.size() - n0);
        end else begin
            nchk++;
            if (vq[n0] !== 8'h03 || vp[n0] !== 1'b0) begin
                errs++; $display("FAIL par_good got=%h/p%b exp=03/p0", vq[n0], vp[n0]);
            end
            nchk++;
            if (vq[n0+1] !== 8'h03 || vp[n0+1] !== 1'b1) begin
                errs++;
                $display("FAIL par_bad got=%h/p%b exp=03/p1", vq[n0+1], vp[n0+1]);
            end
        end
    endtask
`endif

    task automatic test_strobes();
        nchk++;
        if (both_n !== 0 || plone_n !== 0) begin
            errs++;
            $display("FAIL strobe_overlap got=%0d/%0d exp=0/0", both_n, plone_n);
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        reset = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_random();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_strobes();
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that deserialises an asynchronous 8N1-style serial line into parallel words. Bit timing and framing (start bit, DATA_BITS LSB-first, one stop bit) match the team's UART transmitter. Sits at the pin-facing edge of the serial link: it feeds a host/FIFO with a one-cycle valid strobe plus error flags.

Parameters:
BAUD_RATE, 9600, line bit rate in bits/s
CLOCK_FREQ, 50000000, clock frequency in Hz
DATA_BITS, 8, data bits per frame (1..16)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
rx  input  1  raw serial line, asynchronous to clock, idle high
rx_data  output  DATA_BITS  last successfully received word, LSB = first bit on the line
rx_valid  output  1  one-cycle pulse: rx_data updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
parity_err  output  1  one-cycle pulse: parity mismatch (macro only, else constant 0)
rx_busy  output  1  high whenever state != IDLE

Behaviour:
- Constants: BIT_CYCLES = CLOCK_FREQ/BAUD_RATE (integer division); BIT_PERIOD = BIT_CYCLES+1 clocks per bit; HALF = BIT_PERIOD/2 (integer).
- Reset (async): state=IDLE, counters=0, shift reg=0, rx_data=0, rx_valid=0, frame_err=0, parity_err=0. Both synchroniser flops reset to 1. rx_busy=0. Reset mid-frame aborts the frame with no strobe.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s only.
- States: IDLE, START, DATA, STOP, WAIT_IDLE (plus PARITY with macro).
- IDLE: clk_cnt=0, bit_cnt=0. If rx_s==0, go to START.
- START: clk_cnt increments. On the HALF-th clock in START, sample rx_s. If 0, go to DATA with clk_cnt=0. If 1 (glitch/false start), return to IDLE with no strobe.
- DATA: clk_cnt counts to BIT_PERIOD-1, then samples rx_s: shift in at MSB and right-shift, clk_cnt=0. After DATA_BITS samples, go to STOP. Otherwise bit_cnt increments.
- Sample k (k≥1) therefore lands exactly BIT_PERIOD clocks after sample k-1, i.e. mid-bit.
- STOP: sample at BIT_PERIOD.
  - If rx_s==1: rx_data<=shift reg and rx_valid=1 for exactly one cycle, same edge. Go to IDLE.
  - If rx_s==0: frame_err=1 for one cycle, rx_data unchanged, go to WAIT_IDLE.
- WAIT_IDLE: hold until rx_s==1 (covers break condition), then go to IDLE. No repeated error pulses.
- rx_data holds its value until the next valid frame. There is no back-pressure: the consumer must take data on the rx_valid strobe.
- A new start bit is accepted on the clock after returning to IDLE (back-to-back frames with one stop bit supported).
- Strobes are never asserted simultaneously except parity_err with rx_valid.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: an even-parity bit is expected after the data bits. A PARITY state samples it BIT_PERIOD after the last data sample, then proceeds to STOP. On a good stop bit, rx_valid pulses and rx_data updates. If XOR(data, parity bit) != 0, parity_err pulses in the same cycle as rx_valid. On a bad stop bit, only frame_err pulses.
- Undefined: no parity bit in the frame, no PARITY state, parity_err tied to 0.

Test Plan:
Use CLOCK_FREQ=16, BAUD_RATE=1 (BIT_PERIOD=17, HALF=8) unless stated.
1. Reset with rx=1 -> all outputs 0, rx_busy=0. Drive 0x55 frame (start 0, bits 1,0,1,0,1,0,1,0 LSB first, stop 1), 17 clocks/bit -> exactly one rx_valid pulse, rx_data=0x55, frame_err=0.
2. Back-to-back frames 0xAB then 0x2A with no idle gap -> two rx_valid pulses, rx_data=0xAB then 0x2A, ~170 clocks apart.
3. rx low for 4 clocks, then high -> returns to IDLE, no rx_valid, no frame_err, rx_busy drops.
4. Frame 0xAA with stop bit driven 0, then line held low 100 clocks -> single frame_err pulse, rx_data keeps its previous value, rx_busy high until rx returns 1.
5. Assert reset mid-DATA of frame 0xFF -> outputs 0 immediately, no strobe. Following 0x0F frame received correctly.
6. With UART_RX_PARITY_EN: 0x03 with parity 0 -> rx_valid, parity_err=0. 0x03 with parity 1 -> rx_valid and parity_err pulse together, rx_data=0x03.
